uart_tx_ctrl: RTL and testbench

- Buffers 32-bit output words from the core and sequences them, byte by byte, into the 8-bit UART transmitter.
- Drives the transmitter's sdata/tx_start and watches its tx_busy.
- Each queued entry carries a byte count of 1-4, so the core can print single characters or whole words.
- Sits between the core's output-port write path and the UART transmitter instance.

---
 rtl/uart_tx_ctrl_if.sv | 36 +++
 rtl/uart_tx_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
// Bundles every non-clock signal of uart_tx_ctrl: the core-side write path,
// the FIFO status/overflow flags and the handshake with the UART transmitter.
//   master : the environment side (core write port + UART transmitter).
//            Drives wr_en/wr_data/wr_len/ovf_clr and tx_busy.
//   slave  : the controller side. Drives fifo_full/fifo_empty/fifo_count,
//            overflow, ctrl_busy, tx_sdata and tx_start.
interface uart_tx_ctrl_if #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
);
  logic        wr_en;
  logic [31:0] wr_data;
  logic [1:0]  wr_len;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        overflow;
  logic        ovf_clr;
  logic        ctrl_busy;
  logic [7:0]  tx_sdata;
  logic        tx_start;
  logic        tx_busy;

  modport master (
    output wr_en, wr_data, wr_len, ovf_clr, tx_busy,
    input  fifo_full, fifo_empty, fifo_count, overflow, ctrl_busy,
           tx_sdata, tx_start
  );

  modport slave (
    input  wr_en, wr_data, wr_len, ovf_clr, tx_busy,
    output fifo_full, fifo_empty, fifo_count, overflow, ctrl_busy,
           tx_sdata, tx_start
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// Buffers 32-bit words from the core in a DEPTH-entry FIFO and feeds them,
// LSB byte first, to an 8-bit UART transmitter. Each entry carries its own
// byte count (wr_len + 1, i.e. 1..4 bytes).
// Ports:
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : uart_tx_ctrl_if.slave
//           wr_en/wr_data/wr_len  enqueue path from the core
//           fifo_full/fifo_empty/fifo_count  registered FIFO status
//           overflow/ovf_clr      sticky dropped-write flag and its clear
//           ctrl_busy             FSM active or FIFO not empty
//           tx_sdata/tx_start     byte and one-cycle start to the transmitter
//           tx_busy               transmitter busy flag
module uart_tx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rstn,
  uart_tx_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [33:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  // Sequencer state
  state_t        state_q;
  logic [31:0]   shreg_q;
  logic [1:0]    rem_q;
  logic [7:0]    sdata_q;
  logic          start_q;

  logic          push;
  logic          drop;
  logic          pop;
  logic          idle_next;
  logic [33:0]   head;

  assign head = mem[rd_ptr_q];
  assign push = bus.wr_en && !full_q;
  assign drop = bus.wr_en && full_q;
  // The head is only launched once the transmitter is free, so tx_start can
  // never coincide with tx_busy even if the transmitter is held busy.
  assign pop  = (state_q == IDLE) && !empty_q && !bus.tx_busy;

  // Next-state for the FIFO pointers, occupancy flags, overflow and
  // ctrl_busy. Flags are derived from the next count so they are registered
  // on the same edge as the write/pop that changes the occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);

    // A dropped write wins over a simultaneous clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // Whether the sequencer will sit in IDLE after this edge.
    idle_next = ((state_q == IDLE) && !pop) ||
                ((state_q == DONE) && !bus.tx_busy && (rem_q == 2'd0));
    busy_d    = !idle_next || !empty_d;
  end

  // FIFO data array; contents need no reset because the pointers define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {bus.wr_len, bus.wr_data};
    end
  end

  // FIFO control and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  // Byte sequencer: launch a byte, wait for the transmitter to accept it
  // (tx_busy high), then wait for it to finish before the next byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      sdata_q <= '0;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= head[31:0];
            rem_q   <= head[33:32];
            sdata_q <= head[7:0];
            start_q <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          start_q <= 1'b0;
          if (bus.tx_busy) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!bus.tx_busy) begin
            if (rem_q != 2'd0) begin
              rem_q   <= rem_q - 2'd1;
              shreg_q <= shreg_q >> 8;
              sdata_q <= shreg_q[15:8];
              start_q <= 1'b1;
              state_q <= ACK;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.ctrl_busy  = busy_q;
  assign bus.tx_sdata   = sdata_q;
  assign bus.tx_start   = start_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl. Contains a behavioural UART
// transmitter (CLK_PER_HALF_BIT = 4), a serial decoder, and a transaction
// level model of the controller: a queue of expected bytes plus an occupancy
// counter. A negedge process compares the DUT against the model every cycle.
module tb_uart_tx_ctrl;
  localparam int DEPTH    = 16;
  localparam int AW       = $clog2(DEPTH);
  localparam int HALF     = 4;
  localparam int BIT_CLKS = 2 * HALF;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  int         m_count    = 0;
  bit         m_ovf      = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] start_log[$];
  logic [7:0] rx_log[$];
  int         start_cnt  = 0;
  bit         prev_busy  = 1'b0;
  bit         prev_start = 1'b0;
  bit         stall      = 1'b0;

  // Behavioural transmitter state
  bit         m_active = 1'b0;
  logic       m_line   = 1'b1;
  logic [9:0] m_frame;
  int         m_bit;
  int         m_cnt;

  assign bus.tx_busy = stall | m_active;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered UART transmitter: samples tx_start on the clock edge, then
  // shifts a start bit, 8 data bits LSB first and a stop bit, 8 clocks each.
  initial begin
    logic       s;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      s = bus.tx_start;
      d = bus.tx_sdata;
      #1;
      if (!rstn) begin
        m_active = 1'b0;
        m_line   = 1'b1;
      end else if (!m_active) begin
        if (s === 1'b1) begin
          m_active = 1'b1;
          m_frame  = {1'b1, d, 1'b0};
          m_bit    = 0;
          m_cnt    = 0;
          m_line   = 1'b0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == BIT_CLKS) begin
          m_cnt = 0;
          m_bit++;
          if (m_bit == 10) begin
            m_active = 1'b0;
            m_line   = 1'b1;
          end else begin
            m_line = m_frame[m_bit];
          end
        end
      end
    end
  end

  // Serial decoder: samples mid-bit and checks each frame against the bytes
  // the controller launched.
  bit         d_active = 1'b0;
  int         d_cnt;
  logic [7:0] d_byte;
  always @(negedge clk) begin
    int k;
    if (!rstn) begin
      d_active = 1'b0;
    end else if (!d_active) begin
      if (m_line == 1'b0) begin
        d_active = 1'b1;
        d_cnt    = 0;
      end
    end else begin
      d_cnt++;
      if (d_cnt % BIT_CLKS == HALF) begin
        k = d_cnt / BIT_CLKS;
        if (k >= 1 && k <= 8) begin
          d_byte[k-1] = m_line;
        end else if (k == 9) begin
          d_active = 1'b0;
          checkOutput("rx_stop_bit", m_line, 1);
          rx_log.push_back(d_byte);
          if (exp_rx_q.size() == 0) begin
            checkOutput("rx_unexpected_byte", exp_rx_q.size(), 1);
          end else begin
            checkOutput("rx_byte", d_byte, exp_rx_q.pop_front());
          end
        end
      end
    end
  end

  // Per-cycle compare against the transaction model. Inputs seen here are
  // the ones sampled at the edge just passed (stimulus changes 2ns later).
  always @(negedge clk) begin
    logic [8:0] e;
    bit         dropped;
    if (!rstn) begin
      m_count    = 0;
      m_ovf      = 1'b0;
      prev_busy  = 1'b0;
      prev_start = 1'b0;
      exp_q.delete();
      exp_rx_q.delete();
      checkOutput("rst_tx_start", bus.tx_start, 0);
      checkOutput("rst_tx_sdata", bus.tx_sdata, 0);
      checkOutput("rst_fifo_count", bus.fifo_count, 0);
      checkOutput("rst_fifo_empty", bus.fifo_empty, 1);
      checkOutput("rst_fifo_full", bus.fifo_full, 0);
      checkOutput("rst_overflow", bus.overflow, 0);
      checkOutput("rst_ctrl_busy", bus.ctrl_busy, 0);
    end else begin
      dropped = 1'b0;
      if (bus.wr_en) begin
        if (m_count < DEPTH) begin
          for (int b = 0; b <= int'(bus.wr_len); b++) begin
            exp_q.push_back({(b == 0) ? 1'b1 : 1'b0, bus.wr_data[8*b +: 8]});
          end
          m_count++;
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;

      if (bus.tx_start) begin
        start_cnt++;
        start_log.push_back(bus.tx_sdata);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tx_start", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_sdata", bus.tx_sdata, e[7:0]);
          exp_rx_q.push_back(e[7:0]);
          if (e[8]) m_count--;
        end
      end

      checkOutput("fifo_count", bus.fifo_count, m_count);
      checkOutput("fifo_empty", bus.fifo_empty, m_count == 0);
      checkOutput("fifo_full", bus.fifo_full, m_count == DEPTH);
      checkOutput("overflow", bus.overflow, m_ovf);
      checkOutput("start_while_busy", bus.tx_start & bus.tx_busy, 0);
      checkOutput("start_pulse_width", prev_start & bus.tx_start, 0);

      if (m_count != 0 || bus.tx_start || (bus.tx_busy && !stall)) begin
        checkOutput("ctrl_busy_active", bus.ctrl_busy, 1);
      end else if (!bus.tx_busy && !prev_busy && !prev_start && exp_q.size() == 0) begin
        checkOutput("ctrl_busy_idle", bus.ctrl_busy, 0);
      end
      prev_busy  = bus.tx_busy;
      prev_start = bus.tx_start;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] l);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_len  = l;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      tick();
      bus.wr_en   = 1'b0;
      bus.ovf_clr = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    idleCycles(1);
    while (!(m_count == 0 && exp_q.size() == 0 && exp_rx_q.size() == 0 &&
             bus.ctrl_busy == 1'b0 && bus.tx_busy == 1'b0) && n < 20000) begin
      tick();
      n++;
    end
    checkOutput({name, "_drain_timeout"}, n >= 20000, 0);
    idleCycles(2);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t1_exp [4];
    int         n;
    t1_exp = '{8'h11, 8'h22, 8'h33, 8'h44};

    rstn        = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.wr_len  = '0;
    bus.ovf_clr = 1'b0;
    idleCycles(3);
    rstn = 1'b1;
    idleCycles(2);

    // Four-byte word, LSB first, with serial decode.
    $display("[TB] four-byte word");
    start_log.delete();
    rx_log.delete();
    applyStimulus(32'h44332211, 2'b11);
    drain("t1");
    checkOutput("t1_start_count", start_log.size(), 4);
    checkOutput("t1_rx_count", rx_log.size(), 4);
    if (start_log.size() == 4 && rx_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("t1_tx_byte", start_log[i], t1_exp[i]);
        checkOutput("t1_rx_byte", rx_log[i], t1_exp[i]);
      end
    end
    checkOutput("t1_ctrl_busy_after", bus.ctrl_busy, 0);

    // Single byte; start registered one edge after the write edge.
    $display("[TB] single byte latency");
    start_log.delete();
    applyStimulus(32'h000000AB, 2'b00);
    idleCycles(1);
    checkOutput("t2_count_after_e0", bus.fifo_count, 1);
    checkOutput("t2_start_after_e0", bus.tx_start, 0);
    idleCycles(1);
    checkOutput("t2_start_after_e1", bus.tx_start, 1);
    checkOutput("t2_sdata_after_e1", bus.tx_sdata, 8'hAB);
    checkOutput("t2_count_after_e1", bus.fifo_count, 0);
    drain("t2");
    checkOutput("t2_start_count", start_log.size(), 1);

    // Fill while stalled, overflow, clear, then write during a pop when full.
    $display("[TB] overflow with stalled transmitter");
    tick();
    stall = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus($urandom, 2'($urandom_range(0, 3)));
    end
    idleCycles(1);
    checkOutput("t3_fifo_full", bus.fifo_full, 1);
    checkOutput("t3_fifo_count", bus.fifo_count, DEPTH);
    checkOutput("t3_overflow", bus.overflow, 1);
    tick();
    bus.ovf_clr = 1'b1;
    idleCycles(1);
    checkOutput("t3_overflow_cleared", bus.overflow, 0);
    tick();
    stall = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = $urandom;
    bus.wr_len  = 2'b11;
    idleCycles(1);
    checkOutput("t4_count_pop_with_write", bus.fifo_count, DEPTH - 1);
    checkOutput("t4_overflow_set", bus.overflow, 1);
    checkOutput("t4_not_full", bus.fifo_full, 0);
    drain("t3");

    // Random traffic across pointer wrap-around.
    $display("[TB] random traffic");
    for (int i = 0; i < 3 * DEPTH; i++) begin
      applyStimulus($urandom, 2'($urandom_range(0, 3)));
      bus.ovf_clr = ($urandom_range(0, 7) == 0);
      idleCycles($urandom_range(0, 120));
    end
    drain("t5");

    // Reset while the second byte is in flight.
    $display("[TB] reset mid-transfer");
    start_cnt = 0;
    applyStimulus($urandom, 2'($urandom_range(1, 3)));
    idleCycles(1);
    n = 0;
    while (start_cnt < 2 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("t6_second_byte_timeout", n >= 1000, 0);
    idleCycles(20);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_tx_start", bus.tx_start, 0);
    checkOutput("t6_rst_tx_sdata", bus.tx_sdata, 0);
    checkOutput("t6_rst_fifo_count", bus.fifo_count, 0);
    checkOutput("t6_rst_fifo_empty", bus.fifo_empty, 1);
    checkOutput("t6_rst_fifo_full", bus.fifo_full, 0);
    checkOutput("t6_rst_overflow", bus.overflow, 0);
    checkOutput("t6_rst_ctrl_busy", bus.ctrl_busy, 0);
    idleCycles(3);
    rstn      = 1'b1;
    start_cnt = 0;
    idleCycles(150);
    checkOutput("t6_starts_after_release", start_cnt, 0);
    start_log.delete();
    applyStimulus($urandom, 2'b11);
    drain("t6");
    checkOutput("t6_new_word_bytes", start_log.size(), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
